// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the parametrised UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_t;

   function automatic int mid_of(input int oversample);
      return oversample / 2;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser on the serial line plus a delayed copy for falling-edge detection.
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_rxd,
   output logic o_rxd_s,
   output logic o_start_edge
);

   logic r_meta;
   logic r_sync;
   logic r_dly;

   // Line idles high, so every stage resets to 1 to avoid a spurious edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_dly  <= 1'b1;
      end else begin
         r_meta <= i_rxd;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign o_rxd_s      = r_sync;
   assign o_start_edge = r_dly & ~r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit sampling and pulsed error reporting.
// Define UART_RX_PARITY_EN to add the parity cell and drive parity_err.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 uart_clk,
   input  logic                 rst,
   input  logic                 uart_rxd,
   input  logic                 fr_full,
   output logic [DATA_BITS-1:0] rf_data,
   output logic                 fr_wrreq,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int MID = mid_of(OVERSAMPLE);
   localparam int TW  = cnt_width(OVERSAMPLE);
   localparam int BW  = cnt_width(DATA_BITS);

   localparam logic [TW-1:0] TICK_S0   = TW'(MID - 1);
   localparam logic [TW-1:0] TICK_S1   = TW'(MID);
   localparam logic [TW-1:0] TICK_DEC  = TW'(MID + 1);
   localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
      $error("OVERSAMPLE must be even and at least 4");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("DATA_BITS must be 5..9");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("STOP_BITS must be 1 or 2");
   end
   if ((PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_parity_odd
      $error("PARITY_ODD must be 0 or 1");
   end

   logic                 w_rxd_s;
   logic                 w_start_edge;
   logic                 w_vote;
   logic                 w_dec;
   logic                 w_end;
   logic                 w_frame;

   uart_rx_state_t       r_state;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bit_cnt;
   logic [1:0]           r_samp;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_frame;
   logic [DATA_BITS-1:0] r_rf_data;
   logic                 r_wrreq;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_busy;

   uart_rx_sync u_sync (
      .i_clk        (uart_clk),
      .i_rst        (rst),
      .i_rxd        (uart_rxd),
      .o_rxd_s      (w_rxd_s),
      .o_start_edge (w_start_edge)
   );

   assign w_vote  = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxd_s) | (r_samp[1] & w_rxd_s);
   assign w_dec   = (r_tick == TICK_DEC);
   assign w_end   = (r_tick == TICK_END);
   assign w_frame = r_frame | ~w_vote;

   // Capture the two early votes; the third is the live sample at the decision tick.
   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_samp <= 2'b11;
      end else if (r_tick == TICK_S0) begin
         r_samp[0] <= w_rxd_s;
      end else if (r_tick == TICK_S1) begin
         r_samp[1] <= w_rxd_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   localparam logic ODD_BIT = (PARITY_ODD != 0);
   logic r_par_err;
   logic r_parity_err;
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   // Receive state machine; all outputs are registered here.
   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tick      <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_frame     <= 1'b0;
         r_rf_data   <= '0;
         r_wrreq     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_wrreq     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         r_tick <= ((r_state == IDLE) || w_end) ? '0 : (r_tick + TICK_ONE);
         case (r_state)
            IDLE: begin
               r_bit_cnt <= '0;
               r_frame   <= 1'b0;
`ifdef UART_RX_PARITY_EN
               r_par_err <= 1'b0;
`endif
               if (w_start_edge) begin
                  r_state <= START;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (w_dec && w_vote) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_end) begin
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_dec) begin
                  r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
               end
               if (w_end) begin
                  if (r_bit_cnt == LAST_DATA) begin
                     r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     r_state   <= PARITY;
`else
                     r_state   <= STOP;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BIT_ONE;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_dec) begin
                  r_par_err <= (w_vote != ((^r_shift) ^ ODD_BIT));
               end
               if (w_end) begin
                  r_state <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_dec) begin
                  r_frame <= w_frame;
                  // Leave mid-cell so a start edge right after the stop bit is caught.
                  if (r_bit_cnt == LAST_STOP) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     if (w_frame) begin
                        r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     end else if (r_par_err) begin
                        r_parity_err <= 1'b1;
`endif
                     end else if (fr_full) begin
                        r_overrun <= 1'b1;
                     end else begin
                        r_wrreq   <= 1'b1;
                        r_rf_data <= r_shift;
                     end
                  end
               end else if (w_end) begin
                  r_bit_cnt <= r_bit_cnt + BIT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rf_data   = r_rf_data;
   assign fr_wrreq  = r_wrreq;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param; with UART_RX_PARITY_EN it runs a 7-bit, 2-stop, even-parity build.
module tb_uart_rx_param;

   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int DB = 7;
   localparam int SB = 2;
   localparam int PB = 1;
`else
   localparam int DB = 8;
   localparam int SB = 1;
   localparam int PB = 0;
`endif
   localparam int NBITS = 1 + DB + PB + SB;
   // Pin edge to visible output: 3 sync/edge cycles + (N-1) cells + MID + 2.
   localparam int LAT = 3 + (NBITS - 1) * OS + OS / 2 + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxd;
   logic          fr_full;
   logic [DB-1:0] rf_data;
   logic          fr_wrreq;
   logic          frame_err;
   logic          parity_err;
   logic          overrun;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   uart_rx_param #(
      .OVERSAMPLE (OS),
      .DATA_BITS  (DB),
      .STOP_BITS  (SB),
      .PARITY_ODD (0)
   ) dut (
      .uart_clk   (clk),
      .rst        (rst),
      .uart_rxd   (rxd),
      .fr_full    (fr_full),
      .rf_data    (rf_data),
      .fr_wrreq   (fr_wrreq),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            wr_cnt   = 0;
   int            fe_cnt   = 0;
   int            pe_cnt   = 0;
   int            ov_cnt   = 0;
   int            busy_cnt = 0;
   int            wr_cyc   = 0;
   logic [DB-1:0] wr_last  = '0;
   logic [DB-1:0] wr_prev  = '0;

   always @(negedge clk) begin
      if (fr_wrreq) begin
         wr_cnt  <= wr_cnt + 1;
         wr_cyc  <= cyc;
         wr_prev <= wr_last;
         wr_last <= rf_data;
      end
      if (frame_err)  fe_cnt   <= fe_cnt + 1;
      if (parity_err) pe_cnt   <= pe_cnt + 1;
      if (overrun)    ov_cnt   <= ov_cnt + 1;
      if (busy)       busy_cnt <= busy_cnt + 1;
   end

   function automatic logic [DB-1:0] m(input logic [8:0] v);
      return v[DB-1:0];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [8:0] data, input logic par_flip,
                             input logic stop_val, output int fall);
      logic [DB-1:0] d;
      d    = data[DB-1:0];
      rxd  = 1'b0;
      fall = cyc;
      tick(OS);
      for (int i = 0; i < DB; i++) begin
         rxd = d[i];
         tick(OS);
      end
      if (PB == 1) begin
         rxd = (^d) ^ par_flip;
         tick(OS);
      end
      for (int i = 0; i < SB; i++) begin
         rxd = stop_val;
         tick(OS);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; rxd = 1'b1; fr_full = 1'b0;
      tick(3);
      checks++; if (rf_data !== '0) begin failures++; $display("FAIL reset_rf_data got=%h exp=0", rf_data); end
      checks++; if (fr_wrreq !== 1'b0) begin failures++; $display("FAIL reset_wrreq got=%b exp=0", fr_wrreq); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_nominal;
      int f, w0, e0;
      w0 = wr_cnt; e0 = fe_cnt + pe_cnt + ov_cnt;
      send_frame(9'h0A5, 1'b0, 1'b1, f);
      tick(4);
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL nominal_wr_count got=%0d exp=1", wr_cnt - w0); end
      checks++; if (wr_last !== m(9'h0A5)) begin failures++; $display("FAIL nominal_data got=%h exp=%h", wr_last, m(9'h0A5)); end
      checks++; if (wr_cyc != f + LAT) begin failures++; $display("FAIL nominal_latency got=%0d exp=%0d", wr_cyc - f, LAT); end
      checks++; if (fe_cnt + pe_cnt + ov_cnt - e0 != 0) begin failures++; $display("FAIL nominal_errs got=%0d exp=0", fe_cnt + pe_cnt + ov_cnt - e0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nominal_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_false_start;
      int b0, p0;
      b0 = busy_cnt; p0 = wr_cnt + fe_cnt + pe_cnt + ov_cnt;
      rxd = 1'b0;
      tick(5);
      rxd = 1'b1;
      tick(11);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL false_busy_16 got=%b exp=0", busy); end
      checks++; if (busy_cnt - b0 != 10) begin failures++; $display("FAIL false_busy_cycles got=%0d exp=10", busy_cnt - b0); end
      tick(30);
      checks++; if (wr_cnt + fe_cnt + pe_cnt + ov_cnt - p0 != 0) begin failures++; $display("FAIL false_pulses got=%0d exp=0", wr_cnt + fe_cnt + pe_cnt + ov_cnt - p0); end
      checks++; if (rf_data !== m(9'h0A5)) begin failures++; $display("FAIL false_rf_data got=%h exp=%h", rf_data, m(9'h0A5)); end
   endtask

   task automatic test_frame_error;
      int f, w0, fe0, b0;
      w0 = wr_cnt; fe0 = fe_cnt;
      send_frame(9'h03C, 1'b0, 1'b0, f);
      tick(4);
      checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL frame_err_count got=%0d exp=1", fe_cnt - fe0); end
      checks++; if (wr_cnt - w0 != 0) begin failures++; $display("FAIL frame_wr_count got=%0d exp=0", wr_cnt - w0); end
      checks++; if (rf_data !== m(9'h0A5)) begin failures++; $display("FAIL frame_rf_hold got=%h exp=%h", rf_data, m(9'h0A5)); end
      b0 = busy_cnt;
      tick(60);
      checks++; if (busy_cnt - b0 != 0) begin failures++; $display("FAIL frame_break_busy got=%0d exp=0", busy_cnt - b0); end
      rxd = 1'b1;
      tick(20);
      w0 = wr_cnt;
      send_frame(9'h03C, 1'b0, 1'b1, f);
      tick(4);
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL frame_recover_wr got=%0d exp=1", wr_cnt - w0); end
      checks++; if (rf_data !== m(9'h03C)) begin failures++; $display("FAIL frame_recover_data got=%h exp=%h", rf_data, m(9'h03C)); end
   endtask

   task automatic test_overrun;
      int f, w0, ov0;
      w0 = wr_cnt; ov0 = ov_cnt;
      fr_full = 1'b1;
      send_frame(9'h055, 1'b0, 1'b1, f);
      tick(4);
      fr_full = 1'b0;
      checks++; if (ov_cnt - ov0 != 1) begin failures++; $display("FAIL overrun_count got=%0d exp=1", ov_cnt - ov0); end
      checks++; if (wr_cnt - w0 != 0) begin failures++; $display("FAIL overrun_wr got=%0d exp=0", wr_cnt - w0); end
      checks++; if (rf_data !== m(9'h03C)) begin failures++; $display("FAIL overrun_rf_hold got=%h exp=%h", rf_data, m(9'h03C)); end
      send_frame(9'h066, 1'b0, 1'b1, f);
      tick(4);
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL overrun_next_wr got=%0d exp=1", wr_cnt - w0); end
      checks++; if (rf_data !== m(9'h066)) begin failures++; $display("FAIL overrun_next_data got=%h exp=%h", rf_data, m(9'h066)); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int f, w0, pe0;
      w0 = wr_cnt; pe0 = pe_cnt;
      send_frame(9'h041, 1'b0, 1'b1, f);
      tick(4);
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL parity_good_wr got=%0d exp=1", wr_cnt - w0); end
      checks++; if (rf_data !== 7'h41) begin failures++; $display("FAIL parity_good_data got=%h exp=41", rf_data); end
      send_frame(9'h041, 1'b1, 1'b1, f);
      tick(4);
      checks++; if (pe_cnt - pe0 != 1) begin failures++; $display("FAIL parity_bad_count got=%0d exp=1", pe_cnt - pe0); end
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL parity_bad_wr got=%0d exp=1", wr_cnt - w0); end
   endtask
`endif

   task automatic test_back_to_back;
      int f1, f2, w0;
      w0 = wr_cnt;
      send_frame(9'h012, 1'b0, 1'b1, f1);
      send_frame(9'h034, 1'b0, 1'b1, f2);
      tick(4);
      checks++; if (wr_cnt - w0 != 2) begin failures++; $display("FAIL b2b_wr_count got=%0d exp=2", wr_cnt - w0); end
      checks++; if (wr_prev !== m(9'h012)) begin failures++; $display("FAIL b2b_first got=%h exp=%h", wr_prev, m(9'h012)); end
      checks++; if (wr_last !== m(9'h034)) begin failures++; $display("FAIL b2b_second got=%h exp=%h", wr_last, m(9'h034)); end
      checks++; if (wr_cyc != f2 + LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", wr_cyc - f2, LAT); end
   endtask

   task automatic test_reset_mid;
      int p0;
      p0 = wr_cnt + fe_cnt + pe_cnt + ov_cnt;
      rxd = 1'b0;
      tick(OS + OS + OS / 2);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
      rst = 1'b1; rxd = 1'b1;
      tick(1);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (rf_data !== '0) begin failures++; $display("FAIL rstmid_rf_data got=%h exp=0", rf_data); end
      tick(1);
      rst = 1'b0;
      tick(200);
      checks++; if (wr_cnt + fe_cnt + pe_cnt + ov_cnt - p0 != 0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", wr_cnt + fe_cnt + pe_cnt + ov_cnt - p0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_end got=%b exp=0", busy); end
   endtask

   initial begin
      rst = 1'b1; rxd = 1'b1; fr_full = 1'b0;
      test_reset();
      test_nominal();
      test_false_start();
      test_frame_error();
      test_overrun();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
